// File: rtl/lcd_char_rx_if.sv
// Bus and viewer signals of the LCD character receiver.
// The master side drives the character bus and the viewer index; the slave side is the receiver.
interface lcd_char_rx_if;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [4:0] disp_addr;
   logic [7:0] disp_char;
   logic       disp_on;
   logic       two_line;
   logic       busy;
   logic       ovr_err;

   modport master (
      output lcd_e, lcd_rs, lcd_rw, lcd_data, disp_addr,
      input  rd_data, rd_valid, disp_char, disp_on, two_line, busy, ovr_err
   );

   modport slave (
      input  lcd_e, lcd_rs, lcd_rw, lcd_data, disp_addr,
      output rd_data, rd_valid, disp_char, disp_on, two_line, busy, ovr_err
   );
endinterface

// File: rtl/lcd_char_rx.sv
// HD44780-style character bus receiver: decodes bus writes into a 32x8 DDRAM with a viewer port.
// Define LCD_RX_READ_EN to compile in bus reads; by default rw=1 transactions are ignored.
module lcd_char_rx (
   input  logic         clk_100hz,
   input  logic         rst,
   lcd_char_rx_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] ddram_r [0:31];
   logic       e_prev_r;
   logic       cmd_rs_r;
`ifdef LCD_RX_READ_EN
   logic       cmd_rw_r;
`endif
   logic [7:0] cmd_data_r;
   logic [6:0] addr_r;
   logic [6:0] addr_nxt_s;
   logic       inc_r;
   logic       inc_nxt_s;
   logic       disp_on_r;
   logic       disp_on_nxt_s;
   logic       two_line_r;
   logic       two_line_nxt_s;
   logic       busy_r;
   logic       ovr_err_r;
   logic [4:0] clr_cnt_r;
   logic [4:0] clr_cnt_nxt_s;
   logic [7:0] disp_char_r;
   logic [7:0] rd_data_r;
   logic [7:0] rd_data_nxt_s;
   logic       rd_valid_r;
   logic       rd_valid_nxt_s;
   logic       txn_s;
   logic       wr_en_s;
   logic [4:0] wr_idx_s;
   logic [7:0] wr_val_s;

   // Bus address keeps only the line bit and the column nibble.
   function automatic logic [4:0] ddram_idx(input logic [6:0] a);
      return {a[6], a[3:0]};
   endfunction

   function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
      logic [6:0] r;
      if (up) begin
         if (a[3:0] == 4'hF) r = a[6] ? 7'h00 : 7'h40;
         else                r = {a[6], 2'b00, a[3:0] + 4'h1};
      end else begin
         if (a[3:0] == 4'h0) r = a[6] ? 7'h0F : 7'h4F;
         else                r = {a[6], 2'b00, a[3:0] - 4'h1};
      end
      return r;
   endfunction

`ifdef LCD_RX_READ_EN
   assign txn_s = bus.lcd_e & ~e_prev_r;
`else
   assign txn_s = bus.lcd_e & ~e_prev_r & ~bus.lcd_rw;
`endif

   // FSM state register.
   always_ff @(posedge clk_100hz or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nxt_s;
   end

   // Next-state, instruction execution and DDRAM write selection.
   always_comb begin
      state_nxt_s    = state_r;
      addr_nxt_s     = addr_r;
      inc_nxt_s      = inc_r;
      disp_on_nxt_s  = disp_on_r;
      two_line_nxt_s = two_line_r;
      clr_cnt_nxt_s  = clr_cnt_r;
      rd_data_nxt_s  = rd_data_r;
      rd_valid_nxt_s = 1'b0;
      wr_en_s        = 1'b0;
      wr_idx_s       = 5'd0;
      wr_val_s       = 8'h20;
      case (state_r)
         ST_IDLE: begin
            if (txn_s) state_nxt_s = ST_EXEC;
            else       state_nxt_s = ST_IDLE;
         end
         ST_EXEC: begin
            state_nxt_s = ST_IDLE;
`ifdef LCD_RX_READ_EN
            if (cmd_rw_r) begin
               rd_valid_nxt_s = 1'b1;
               if (cmd_rs_r) begin
                  rd_data_nxt_s = ddram_r[ddram_idx(addr_r)];
                  addr_nxt_s    = addr_step(addr_r, inc_r);
               end else begin
                  // Reads are only accepted while idle, so the reported busy flag is clear.
                  rd_data_nxt_s = {1'b0, addr_r};
               end
            end else
`endif
            if (cmd_rs_r) begin
               wr_en_s    = 1'b1;
               wr_idx_s   = ddram_idx(addr_r);
               wr_val_s   = cmd_data_r;
               addr_nxt_s = addr_step(addr_r, inc_r);
            end else begin
               casez (cmd_data_r)
                  8'b1???????: addr_nxt_s     = {cmd_data_r[6], 2'b00, cmd_data_r[3:0]};
                  8'b01??????: addr_nxt_s     = addr_r;
                  8'b001?????: two_line_nxt_s = cmd_data_r[3];
                  8'b0001????: addr_nxt_s     = addr_r;
                  8'b00001???: disp_on_nxt_s  = cmd_data_r[2];
                  8'b000001??: inc_nxt_s      = cmd_data_r[1];
                  8'b0000001?: addr_nxt_s     = 7'h00;
                  8'b00000001: begin
                     clr_cnt_nxt_s = 5'd0;
                     state_nxt_s   = ST_CLEAR;
                  end
                  default:     addr_nxt_s     = addr_r;
               endcase
            end
         end
         ST_CLEAR: begin
            wr_en_s  = 1'b1;
            wr_idx_s = clr_cnt_r;
            wr_val_s = 8'h20;
            if (clr_cnt_r == 5'd31) begin
               addr_nxt_s  = 7'h00;
               state_nxt_s = ST_IDLE;
            end else begin
               clr_cnt_nxt_s = clr_cnt_r + 5'd1;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Control registers, command capture, status flags and viewer output.
   always_ff @(posedge clk_100hz or posedge rst) begin
      if (rst) begin
         e_prev_r    <= 1'b0;
         cmd_rs_r    <= 1'b0;
`ifdef LCD_RX_READ_EN
         cmd_rw_r    <= 1'b0;
`endif
         cmd_data_r  <= 8'h00;
         addr_r      <= 7'h00;
         inc_r       <= 1'b1;
         disp_on_r   <= 1'b0;
         two_line_r  <= 1'b0;
         busy_r      <= 1'b0;
         ovr_err_r   <= 1'b0;
         clr_cnt_r   <= 5'd0;
         rd_data_r   <= 8'h00;
         rd_valid_r  <= 1'b0;
         disp_char_r <= 8'h00;
      end else begin
         e_prev_r <= bus.lcd_e;
         if (txn_s && (state_r == ST_IDLE)) begin
            cmd_rs_r   <= bus.lcd_rs;
`ifdef LCD_RX_READ_EN
            cmd_rw_r   <= bus.lcd_rw;
`endif
            cmd_data_r <= bus.lcd_data;
         end
         if (txn_s && busy_r) ovr_err_r <= 1'b1;
         addr_r      <= addr_nxt_s;
         inc_r       <= inc_nxt_s;
         disp_on_r   <= disp_on_nxt_s;
         two_line_r  <= two_line_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
         clr_cnt_r   <= clr_cnt_nxt_s;
         rd_data_r   <= rd_data_nxt_s;
         rd_valid_r  <= rd_valid_nxt_s;
         // Non-blocking read of the array returns the pre-write value on a same-index collision.
         disp_char_r <= ddram_r[bus.disp_addr];
      end
   end

   // DDRAM storage.
   always_ff @(posedge clk_100hz or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) ddram_r[i] <= 8'h20;
      end else if (wr_en_s) begin
         ddram_r[wr_idx_s] <= wr_val_s;
      end
   end

   assign bus.rd_data   = rd_data_r;
   assign bus.rd_valid  = rd_valid_r;
   assign bus.disp_char = disp_char_r;
   assign bus.disp_on   = disp_on_r;
   assign bus.two_line  = two_line_r;
   assign bus.busy      = busy_r;
   assign bus.ovr_err   = ovr_err_r;
endmodule

// File: tb/tb_lcd_char_rx.sv
// Randomized self-checking bench for lcd_char_rx against a line/column display model.
module tb_lcd_char_rx;
   logic clk_100hz = 1'b0;
   logic rst;
   lcd_char_rx_if bus_if();

   lcd_char_rx dut (
      .clk_100hz (clk_100hz),
      .rst       (rst),
      .bus       (bus_if)
   );

   always #5 clk_100hz = ~clk_100hz;

   int err_cnt = 0;
   int chk_cnt = 0;

   logic [7:0] m_mem [32];
   int m_line, m_col;
   bit m_inc, m_disp_on, m_two_line, m_ovr;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_idx();
      return m_line * 16 + m_col;
   endfunction

   function automatic logic [7:0] m_addr();
      return 8'(m_line * 64 + m_col);
   endfunction

   task automatic m_advance();
      if (m_inc) begin
         m_col++;
         if (m_col == 16) begin m_col = 0; m_line = 1 - m_line; end
      end else begin
         m_col--;
         if (m_col < 0) begin m_col = 15; m_line = 1 - m_line; end
      end
   endtask

   task automatic m_reset();
      foreach (m_mem[i]) m_mem[i] = 8'h20;
      m_line = 0; m_col = 0; m_inc = 1'b1;
      m_disp_on = 1'b0; m_two_line = 1'b0; m_ovr = 1'b0;
   endtask

   // Display model: one accepted transaction, decoded by value range.
   task automatic m_apply(input bit rs, input bit rw, input logic [7:0] d, output logic [7:0] rd_exp);
      rd_exp = 8'h00;
      if (rw) begin
`ifdef LCD_RX_READ_EN
         if (rs) begin rd_exp = m_mem[m_idx()]; m_advance(); end
         else rd_exp = m_addr();
`endif
      end else if (rs) begin
         m_mem[m_idx()] = d;
         m_advance();
      end else if (d >= 8'h80) begin
         m_line = int'(d[6]); m_col = int'(d[3:0]);
      end else if (d >= 8'h40) begin
      end else if (d >= 8'h20) m_two_line = d[3];
      else if (d >= 8'h10) begin
      end else if (d >= 8'h08) m_disp_on = d[2];
      else if (d >= 8'h04) m_inc = d[1];
      else if (d >= 8'h02) begin m_line = 0; m_col = 0; end
      else if (d == 8'h01) begin
         foreach (m_mem[i]) m_mem[i] = 8'h20;
         m_line = 0; m_col = 0;
      end
   endtask

   task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] d);
      logic [7:0] dc_old, rd_exp, old_at_view;
      int rv_cnt, n;
      bit done;
      old_at_view = m_mem[bus_if.disp_addr];
      bus_if.lcd_rs = rs; bus_if.lcd_rw = rw; bus_if.lcd_data = d; bus_if.lcd_e = 1'b1;
      @(posedge clk_100hz); #1;
      bus_if.lcd_e = 1'b0;
      rv_cnt = 0; n = 0; done = 1'b0; dc_old = 8'h00;
      while (!done && n < 60) begin
         @(posedge clk_100hz); #1;
         n++;
         if (n == 1) dc_old = bus_if.disp_char;
         if (bus_if.rd_valid) rv_cnt++;
         if (!bus_if.busy) done = 1'b1;
      end
      check_val("xfer_done", 32'(done), 32'd1);
      repeat (2) begin
         @(posedge clk_100hz); #1;
         if (bus_if.rd_valid) rv_cnt++;
      end
      check_val("view_old", dc_old, old_at_view);
      m_apply(rs, rw, d, rd_exp);
      if (rw) begin
`ifdef LCD_RX_READ_EN
         check_val("rd_valid_pulses", rv_cnt, 32'd1);
         check_val("rd_data", bus_if.rd_data, rd_exp);
`else
         check_val("rw_ignored_busy", n, 32'd1);
         check_val("rd_valid_pulses", rv_cnt, 32'd0);
         check_val("rd_data", bus_if.rd_data, 32'h00);
`endif
      end else begin
         check_val("rd_valid_idle", rv_cnt, 32'd0);
      end
      check_val("disp_on", bus_if.disp_on, m_disp_on);
      check_val("two_line", bus_if.two_line, m_two_line);
      check_val("ovr_err", bus_if.ovr_err, m_ovr);
   endtask

   task automatic view(input int idx, input logic [7:0] exp, input string tag);
      bus_if.disp_addr = 5'(idx);
      @(posedge clk_100hz); #1;
      check_val(tag, bus_if.disp_char, exp);
   endtask

   task automatic scan_mem(input string tag);
      for (int i = 0; i < 32; i++) view(i, m_mem[i], $sformatf("%s[%0d]", tag, i));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus_if.lcd_e = 1'b0; bus_if.lcd_rs = 1'b0; bus_if.lcd_rw = 1'b0;
      bus_if.lcd_data = 8'h00; bus_if.disp_addr = 5'd0;
      repeat (3) @(posedge clk_100hz);
      #1 rst = 1'b0;
      m_reset();
      @(posedge clk_100hz); #1;
   endtask

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tmp;
      int busy_cnt;
      bit rs, rw;

      rst = 1'b1;
      bus_if.lcd_e = 1'b0; bus_if.lcd_rs = 1'b0; bus_if.lcd_rw = 1'b0;
      bus_if.lcd_data = 8'h00; bus_if.disp_addr = 5'd0;
      #2;
      check_val("rst_disp_char", bus_if.disp_char, 32'h00);
      check_val("rst_rd_data", bus_if.rd_data, 32'h00);
      check_val("rst_rd_valid", bus_if.rd_valid, 32'd0);
      check_val("rst_busy", bus_if.busy, 32'd0);
      check_val("rst_ovr_err", bus_if.ovr_err, 32'd0);
      check_val("rst_disp_on", bus_if.disp_on, 32'd0);
      check_val("rst_two_line", bus_if.two_line, 32'd0);
      do_reset();
      scan_mem("rst_mem");

      // Set address, write "He", probe next address.
      bus_xfer(1'b0, 1'b0, 8'h80);
      bus_xfer(1'b1, 1'b0, 8'h48);
      bus_xfer(1'b1, 1'b0, 8'h65);
      bus_xfer(1'b1, 1'b0, 8'h21);
      view(0, 8'h48, "hello_0");
      view(1, 8'h65, "hello_1");
      view(2, 8'h21, "hello_addr2");

      // Line wrap 0x0F -> 0x40.
      bus_xfer(1'b0, 1'b0, 8'h8F);
      bus_xfer(1'b1, 1'b0, 8'h41);
      bus_xfer(1'b1, 1'b0, 8'h42);
      bus_xfer(1'b1, 1'b0, 8'h43);
      view(15, 8'h41, "wrap_15");
      view(16, 8'h42, "wrap_16");
      view(17, 8'h43, "wrap_addr41");

      // Decrement wrap 0x00 -> 0x4F.
      bus_xfer(1'b0, 1'b0, 8'h04);
      bus_xfer(1'b0, 1'b0, 8'h80);
      bus_xfer(1'b1, 1'b0, 8'h5A);
      bus_xfer(1'b1, 1'b0, 8'h5B);
      view(0, 8'h5A, "dec_0");
      view(31, 8'h5B, "dec_addr4f");
      bus_xfer(1'b0, 1'b0, 8'h06);

      // Display flags.
      bus_xfer(1'b0, 1'b0, 8'h0C);
      bus_xfer(1'b0, 1'b0, 8'h28);
      bus_xfer(1'b0, 1'b0, 8'h08);

      // Held strobe yields a single write.
      bus_xfer(1'b0, 1'b0, 8'h85);
      bus_if.lcd_rs = 1'b1; bus_if.lcd_rw = 1'b0; bus_if.lcd_data = 8'h77; bus_if.lcd_e = 1'b1;
      repeat (6) @(posedge clk_100hz);
      #1 bus_if.lcd_e = 1'b0;
      repeat (3) @(posedge clk_100hz);
      #1;
      m_apply(1'b1, 1'b0, 8'h77, tmp);
      check_val("held_e_ovr", bus_if.ovr_err, 32'd0);
      scan_mem("held_e_mem");

      // Read-back (only effective with bus reads compiled in).
      bus_xfer(1'b0, 1'b0, 8'hC3);
      bus_xfer(1'b0, 1'b1, 8'h00);
      bus_xfer(1'b1, 1'b0, 8'h55);
      bus_xfer(1'b0, 1'b0, 8'hC3);
      bus_xfer(1'b1, 1'b1, 8'h00);

      // Clear with an overrun transaction during it.
      bus_if.lcd_rs = 1'b0; bus_if.lcd_rw = 1'b0; bus_if.lcd_data = 8'h01; bus_if.lcd_e = 1'b1;
      @(posedge clk_100hz); #1;
      bus_if.lcd_e = 1'b0;
      busy_cnt = bus_if.busy ? 1 : 0;
      for (int k = 1; k <= 60; k++) begin
         if (k == 5) begin
            bus_if.lcd_rs = 1'b1; bus_if.lcd_data = 8'h31; bus_if.lcd_e = 1'b1;
         end
         if (k == 6) bus_if.lcd_e = 1'b0;
         @(posedge clk_100hz); #1;
         if (bus_if.busy) busy_cnt++;
      end
      m_apply(1'b0, 1'b0, 8'h01, tmp);
      m_ovr = 1'b1;
      check_val("clear_busy_cycles", busy_cnt, 32'd33);
      check_val("clear_ovr_err", bus_if.ovr_err, 32'd1);
      scan_mem("clear_mem");
      bus_xfer(1'b1, 1'b0, 8'h99);
      view(0, 8'h99, "post_clear_addr0");

      // Reset in the middle of a clear.
      bus_if.lcd_rs = 1'b0; bus_if.lcd_rw = 1'b0; bus_if.lcd_data = 8'h01; bus_if.lcd_e = 1'b1;
      @(posedge clk_100hz); #1;
      bus_if.lcd_e = 1'b0;
      repeat (11) @(posedge clk_100hz);
      #1;
      check_val("midclr_busy_before", bus_if.busy, 32'd1);
      rst = 1'b1;
      #1;
      check_val("midclr_busy", bus_if.busy, 32'd0);
      check_val("midclr_ovr_err", bus_if.ovr_err, 32'd0);
      check_val("midclr_disp_char", bus_if.disp_char, 32'h00);
      repeat (2) @(posedge clk_100hz);
      #1 rst = 1'b0;
      m_reset();
      scan_mem("midclr_mem");

      // Randomized traffic against the model.
      for (int it = 0; it < 120; it++) begin
         rs = 1'($urandom_range(0, 1));
         rw = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 0) bus_if.disp_addr = 5'(m_idx());
         else                           bus_if.disp_addr = 5'($urandom_range(0, 31));
         bus_xfer(rs, rw, 8'($urandom));
      end
      scan_mem("rand_mem");

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
